uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
Boot-time loader that sits directly upstream of the program memory and processor control. It receives a program over a UART RX line, oversampled 16x from the baud tick, and assembles byte pairs into 16-bit instructions, high byte first. Each instruction is written sequentially into program memory, and the processor is held in reset until loading completes. It is the receive-side mirror of the accumulator-dump path, which sends words as high byte then low byte over TX.

Parameters:
ADDR_W, 11, program memory address width
MAX_WORDS, 2048, capacity; loading ends when address MAX_WORDS-1 is written
OVERSAMPLE, 16, baud ticks per bit; mid-bit sample at tick OVERSAMPLE/2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
baud_tick  in  1  one-clk pulse at 16x bit rate, from the baud rate generator
rx  in  1  UART serial input, idle high, asynchronous to clk
prog_we  out  1  program memory write strobe, one clk per word
prog_addr  out  ADDR_W  write address
prog_data  out  16  instruction word to write
cpu_rst_n  out  1  processor reset, low while loading, high once done
done  out  1  load complete, sticky until rst
frame_err  out  1  sticky: a stop bit was sampled low
word_count  out  ADDR_W+1  number of words written

Behaviour:
- Reset (rst=0 at a clk edge): every output is 0, including cpu_rst_n. The byte phase returns to HIGH, the RX FSM to IDLE, and the sync flops to 1. Reset mid-frame or mid-word discards the partial data.
- rx passes through a 2-flop synchronizer. All decisions use the synchronized value, so rx latency is 2 clk.
- Tick counters advance only on cycles with baud_tick=1.
- RX FSM states and transitions:
  - IDLE: a synchronized rx of 0 moves to START and clears tick_cnt.
  - START: after 8 ticks, sample rx. If 0, go to DATA with bit_idx=0 and tick_cnt=0. If 1, treat it as a glitch and return to IDLE.
  - DATA: every 16 ticks, sample one bit into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after 16 ticks, sample rx. If 1, the byte is valid. If 0, set frame_err, discard the byte, force byte phase to HIGH, and do not write. Both cases return to IDLE.
  - DONE: rx is ignored until rst.
- Word assembly:
  - A valid byte in phase HIGH goes to prog_data[15:8], and the phase becomes LOW.
  - A valid byte in phase LOW goes to prog_data[7:0], and the phase becomes HIGH.
- Write timing:
  - prog_we=1 for exactly one clk, on the cycle after the LOW-byte stop sample.
  - prog_addr and prog_data are stable during the strobe.
  - On the clk after the strobe, prog_addr and word_count each increment by 1, and prog_we returns to 0.
- Termination:
  - A written word of 0x0000 (halt terminator) ends loading; the word itself is written.
  - A write to address MAX_WORDS-1 also ends loading; prog_addr does not wrap.
  - On the clk after the final strobe, enter DONE: done=1 and cpu_rst_n=1, both held until rst.
- The next start edge is accepted in the same cycle as a write strobe; no RX bits are lost during the write.
- frame_err does not stop loading. The next valid byte is treated as a HIGH byte.

Test Plan:
- Tick every 4 clk, send bytes 0x08,0x05 then 0x00,0x00. Required: writes addr0=0x0805 and addr1=0x0000, each with prog_we high 1 clk; word_count=2; done=1 and cpu_rst_n=1 one clk after the second strobe.
- Send 0xA5 with the stop bit forced low, then 0x12,0x34,0x00,0x00. Required: frame_err=1; first write is addr0=0x1234, proving the phase was resynced to HIGH.
- A 4-tick low glitch on idle rx. Required: no byte is received and there is no write; the FSM is back in IDLE.
- Assert rst=0 after a HIGH byte 0x77, mid low-byte. Required: all outputs return to 0; next sending 0x11,0x22,0,0 gives addr0=0x1122.
- With MAX_WORDS=4, stream 5 nonzero words. Required: exactly 4 writes, to addr 0..3; done asserts after addr3; the 5th word is ignored; prog_addr stays at 3.
- Send back-to-back frames with no idle gap, 0xFF,0xFF,0,0. Required: addr0=0xFFFF and addr1=0x0000 are both written correctly, with no missed start bit.

Source files
------------

// File: rtl/uart_program_loader.sv
// uart_program_loader
//
// Boot-time program loader. Receives a program over a UART RX line that is
// oversampled from a 16x baud tick, pairs received bytes into 16-bit
// instructions (high byte first) and writes them sequentially into program
// memory. The processor is held in reset until loading finishes, which
// happens on a 0x0000 halt word or when the last memory address is written.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   baud_tick  one-clk pulse at OVERSAMPLE x bit rate
//   rx         UART serial input, idle high, asynchronous to clk
//   prog_we    program memory write strobe, one clk per word
//   prog_addr  program memory write address
//   prog_data  instruction word being written
//   cpu_rst_n  processor reset, low while loading, high once done
//   done       load complete, sticky until rst
//   frame_err  sticky, set when a stop bit was sampled low
//   word_count number of words written so far
module uart_program_loader #(
    parameter int ADDR_W     = 11,
    parameter int MAX_WORDS  = 2048,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              rx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              frame_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } rx_state_t;

    rx_state_t          state, state_next;
    logic               rx_meta, rx_sync;
    logic [TICK_W-1:0]  tick_cnt, tick_cnt_next;
    logic [2:0]         bit_idx, bit_idx_next;
    logic [7:0]         shift_reg, shift_reg_next;
    logic               phase_low, phase_low_next;
    logic               prog_we_next;
    logic [ADDR_W-1:0]  prog_addr_next;
    logic [15:0]        prog_data_next;
    logic [ADDR_W:0]    word_count_next;
    logic               done_next, frame_err_next, cpu_rst_n_next;
    logic               final_write;

    // Two-flop synchronizer; resets to the idle level so reset never
    // looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            phase_low  <= 1'b0;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_data  <= '0;
            word_count <= '0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            cpu_rst_n  <= 1'b0;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_cnt_next;
            bit_idx    <= bit_idx_next;
            shift_reg  <= shift_reg_next;
            phase_low  <= phase_low_next;
            prog_we    <= prog_we_next;
            prog_addr  <= prog_addr_next;
            prog_data  <= prog_data_next;
            word_count <= word_count_next;
            done       <= done_next;
            frame_err  <= frame_err_next;
            cpu_rst_n  <= cpu_rst_n_next;
        end
    end

    // The word on the strobe is the last one if it is the halt word or it
    // lands on the final address.
    assign final_write = prog_we && ((prog_data == 16'h0000) || (prog_addr == LAST_ADDR));

    always_comb begin
        state_next      = state;
        tick_cnt_next   = tick_cnt;
        bit_idx_next    = bit_idx;
        shift_reg_next  = shift_reg;
        phase_low_next  = phase_low;
        prog_we_next    = 1'b0;
        prog_addr_next  = prog_addr;
        prog_data_next  = prog_data;
        word_count_next = word_count;
        done_next       = done;
        frame_err_next  = frame_err;
        cpu_rst_n_next  = cpu_rst_n;

        case (state)
            S_IDLE: begin
                if (!rx_sync) begin
                    state_next    = S_START;
                    tick_cnt_next = '0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    if (tick_cnt == MID_TICK) begin
                        tick_cnt_next = '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        if (!rx_sync) begin
                            state_next   = S_DATA;
                            bit_idx_next = '0;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_next  = '0;
                        shift_reg_next = {rx_sync, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state_next = S_STOP;
                        end else begin
                            bit_idx_next = bit_idx + 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_next = '0;
                        state_next    = S_IDLE;
                        if (rx_sync) begin
                            if (!phase_low) begin
                                prog_data_next[15:8] = shift_reg;
                                phase_low_next       = 1'b1;
                            end else begin
                                prog_data_next[7:0] = shift_reg;
                                phase_low_next      = 1'b0;
                                prog_we_next        = 1'b1;
                            end
                        end else begin
                            // Bad frame: drop the byte and resync so the next
                            // good byte starts a fresh word.
                            frame_err_next = 1'b1;
                            phase_low_next = 1'b0;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Post-strobe bookkeeping runs alongside the RX FSM so a start edge
        // arriving on the strobe cycle is not lost.
        if (prog_we) begin
            word_count_next = word_count + 1'b1;
            if (prog_addr != LAST_ADDR) begin
                prog_addr_next = prog_addr + 1'b1;
            end
            if (final_write) begin
                state_next     = S_DONE;
                done_next      = 1'b1;
                cpu_rst_n_next = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader
//
// Bench for uart_program_loader. Two instances: dut_a with the default
// 2048-word capacity and dut_b with a 4-word capacity. A word-level loader
// model predicts the sequence of memory writes; a single compare process
// checks strobes, addresses, data, counts and done/cpu_rst_n every cycle.
module tb_uart_program_loader;

    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] data;
        logic        fin;
    } wr_t;

    logic        clk;
    logic        baud_tick;
    logic        rst_a, rst_b;
    logic        rx_a, rx_b;
    logic        we_a, we_b;
    logic [10:0] addr_a, addr_b;
    logic [15:0] data_a, data_b;
    logic        crn_a, crn_b;
    logic        done_a, done_b;
    logic        fe_a, fe_b;
    logic [11:0] wc_a, wc_b;

    int vectors = 0;
    int miscompares = 0;

    wr_t exp_a[$];
    wr_t exp_b[$];

    bit         m_phase[2];
    logic [7:0] m_hi[2];
    int         m_addr[2];
    bit         m_done[2];
    int         m_max[2] = '{2048, 4};

    int          seen[2];
    bit          dlatch[2];
    bit          prev_we[2];
    logic [15:0] log_a[8];
    int          log_a_n;
    int          log_b_n;

    uart_program_loader dut_a (
        .clk(clk), .rst(rst_a), .baud_tick(baud_tick), .rx(rx_a),
        .prog_we(we_a), .prog_addr(addr_a), .prog_data(data_a),
        .cpu_rst_n(crn_a), .done(done_a), .frame_err(fe_a), .word_count(wc_a)
    );

    uart_program_loader #(.ADDR_W(11), .MAX_WORDS(4), .OVERSAMPLE(16)) dut_b (
        .clk(clk), .rst(rst_b), .baud_tick(baud_tick), .rx(rx_b),
        .prog_we(we_b), .prog_addr(addr_b), .prog_data(data_b),
        .cpu_rst_n(crn_b), .done(done_b), .frame_err(fe_b), .word_count(wc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick every 4 clk
    initial begin
        int tdiv;
        tdiv = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tdiv = tdiv + 1;
            baud_tick = ((tdiv % 4) == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setRx(input int d, input logic v);
        if (d == 0) rx_a = v;
        else rx_b = v;
    endtask

    // Word-level loader model: pairs good bytes, drops bad ones and
    // resyncs to a high byte, stops after a halt word or the last address.
    task automatic modelByte(input int d, input logic [7:0] b, input bit good);
        wr_t w;
        if (m_done[d]) return;
        if (!good) begin
            m_phase[d] = 1'b0;
            return;
        end
        if (!m_phase[d]) begin
            m_hi[d]    = b;
            m_phase[d] = 1'b1;
        end else begin
            w.addr = 11'(m_addr[d]);
            w.data = {m_hi[d], b};
            w.fin  = (w.data == 16'h0000) || (m_addr[d] == m_max[d] - 1);
            if (d == 0) exp_a.push_back(w);
            else exp_b.push_back(w);
            m_phase[d] = 1'b0;
            if (w.fin) m_done[d] = 1'b1;
            else m_addr[d]++;
        end
    endtask

    // One UART frame: start, 8 data bits LSB first, stop, then 1 bit idle
    // only for a bad frame (whose stop bit is cut short to 12 ticks).
    task automatic applyStimulus(input int d, input logic [7:0] b, input bit good);
        modelByte(d, b, good);
        setRx(d, 1'b0);
        step(64);
        for (int i = 0; i < 8; i++) begin
            setRx(d, b[i]);
            step(64);
        end
        if (good) begin
            setRx(d, 1'b1);
            step(64);
        end else begin
            setRx(d, 1'b0);
            step(48);
            setRx(d, 1'b1);
            step(64);
        end
    endtask

    task automatic checkZero(input string tag, input logic we, input logic [10:0] addr,
                             input logic [15:0] data, input logic crn, input logic dn,
                             input logic fe, input logic [11:0] wc);
        checkOutput({tag, "_prog_we"}, 32'(we), 32'd0);
        checkOutput({tag, "_prog_addr"}, 32'(addr), 32'd0);
        checkOutput({tag, "_prog_data"}, 32'(data), 32'd0);
        checkOutput({tag, "_cpu_rst_n"}, 32'(crn), 32'd0);
        checkOutput({tag, "_done"}, 32'(dn), 32'd0);
        checkOutput({tag, "_frame_err"}, 32'(fe), 32'd0);
        checkOutput({tag, "_word_count"}, 32'(wc), 32'd0);
    endtask

    task automatic applyReset(input int d, input string tag);
        if (d == 0) rst_a = 1'b0;
        else rst_b = 1'b0;
        step(3);
        if (d == 0) checkZero(tag, we_a, addr_a, data_a, crn_a, done_a, fe_a, wc_a);
        else checkZero(tag, we_b, addr_b, data_b, crn_b, done_b, fe_b, wc_b);
        m_phase[d] = 1'b0;
        m_hi[d]    = '0;
        m_addr[d]  = 0;
        m_done[d]  = 1'b0;
        if (d == 0) exp_a.delete();
        else exp_b.delete();
        setRx(d, 1'b1);
        if (d == 0) rst_a = 1'b1;
        else rst_b = 1'b1;
        step(4);
    endtask

    task automatic waitDone(input int d, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (((d == 0) ? done_a : done_b) === 1'b1) break;
            step(1);
        end
        checkOutput({tag, "_done_within_budget"}, 32'((d == 0) ? done_a : done_b), 32'd1);
    endtask

    task automatic monitor(input int d, input logic we, input logic [10:0] addr,
                           input logic [15:0] data, input logic crn, input logic dn,
                           input logic [11:0] wc);
        wr_t e;
        int  pend;
        string p;
        p = $sformatf("dut%0d", d);
        checkOutput({p, "_word_count"}, 32'(wc), 32'(seen[d]));
        checkOutput({p, "_done"}, 32'(dn), 32'(dlatch[d]));
        checkOutput({p, "_cpu_rst_n"}, 32'(crn), 32'(dlatch[d]));
        if (!dlatch[d]) checkOutput({p, "_prog_addr"}, 32'(addr), 32'(seen[d]));
        if (we === 1'b1) begin
            checkOutput({p, "_strobe_one_clk"}, 32'(prev_we[d]), 32'd0);
            e = '0;
            pend = (d == 0) ? exp_a.size() : exp_b.size();
            checkOutput({p, "_write_expected"}, 32'(pend != 0), 32'd1);
            if (pend != 0) begin
                if (d == 0) e = exp_a.pop_front();
                else e = exp_b.pop_front();
                checkOutput({p, "_write_addr"}, 32'(addr), 32'(e.addr));
                checkOutput({p, "_write_data"}, 32'(data), 32'(e.data));
                if (e.fin) dlatch[d] = 1'b1;
            end
            if (d == 0 && log_a_n < 8) begin
                log_a[log_a_n] = data;
                log_a_n++;
            end
            if (d == 1) log_b_n++;
            seen[d]++;
        end
        prev_we[d] = (we === 1'b1);
    endtask

    // Single compare process for both instances, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_a !== 1'b1) begin
            seen[0] = 0; dlatch[0] = 1'b0; prev_we[0] = 1'b0; log_a_n = 0;
        end else begin
            monitor(0, we_a, addr_a, data_a, crn_a, done_a, wc_a);
        end
        if (rst_b !== 1'b1) begin
            seen[1] = 0; dlatch[1] = 1'b0; prev_we[1] = 1'b0; log_b_n = 0;
        end else begin
            monitor(1, we_b, addr_b, data_b, crn_b, done_b, wc_b);
        end
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        step(2);
        applyReset(0, "reset_a");
        applyReset(1, "reset_b");

        // Basic two-word load with halt terminator
        applyStimulus(0, 8'h08, 1);
        applyStimulus(0, 8'h05, 1);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(0, 8'h00, 1);
        waitDone(0, "t1");
        checkOutput("t1_word0", 32'(log_a[0]), 32'h0805);
        checkOutput("t1_word1", 32'(log_a[1]), 32'h0000);
        checkOutput("t1_word_count", 32'(wc_a), 32'd2);
        checkOutput("t1_cpu_rst_n", 32'(crn_a), 32'd1);
        checkOutput("t1_frame_err", 32'(fe_a), 32'd0);
        applyReset(0, "t1_reset");

        // Bad stop bit as the first byte
        applyStimulus(0, 8'hA5, 0);
        applyStimulus(0, 8'h12, 1);
        applyStimulus(0, 8'h34, 1);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(0, 8'h00, 1);
        waitDone(0, "t2");
        checkOutput("t2_frame_err", 32'(fe_a), 32'd1);
        checkOutput("t2_word0", 32'(log_a[0]), 32'h1234);
        applyReset(0, "t2_reset");

        // Bad stop bit after a high byte: the half word is dropped
        applyStimulus(0, 8'h12, 1);
        applyStimulus(0, 8'hA5, 0);
        applyStimulus(0, 8'h34, 1);
        applyStimulus(0, 8'h56, 1);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(0, 8'h00, 1);
        waitDone(0, "t2b");
        checkOutput("t2b_frame_err", 32'(fe_a), 32'd1);
        checkOutput("t2b_word0", 32'(log_a[0]), 32'h3456);
        applyReset(0, "t2b_reset");

        // Short low glitch on idle line, then a real load
        setRx(0, 1'b0);
        step(16);
        setRx(0, 1'b1);
        step(200);
        checkOutput("t3_no_write_count", 32'(wc_a), 32'd0);
        checkOutput("t3_no_frame_err", 32'(fe_a), 32'd0);
        applyStimulus(0, 8'hAB, 1);
        applyStimulus(0, 8'hCD, 1);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(0, 8'h00, 1);
        waitDone(0, "t3");
        checkOutput("t3_word0", 32'(log_a[0]), 32'hABCD);
        applyReset(0, "t3_reset");

        // Reset in the middle of the low byte
        applyStimulus(0, 8'h77, 1);
        setRx(0, 1'b0);
        step(64);
        for (int i = 0; i < 3; i++) begin
            setRx(0, i[0]);
            step(64);
        end
        applyReset(0, "t4_midword_reset");
        applyStimulus(0, 8'h11, 1);
        applyStimulus(0, 8'h22, 1);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(0, 8'h00, 1);
        waitDone(0, "t4");
        checkOutput("t4_word0", 32'(log_a[0]), 32'h1122);
        checkOutput("t4_word_count", 32'(wc_a), 32'd2);
        applyReset(0, "t4_reset");

        // Capacity limit on the 4-word instance
        for (int w = 1; w <= 5; w++) begin
            applyStimulus(1, 8'(w), 1);
            applyStimulus(1, 8'(w), 1);
        end
        waitDone(1, "t5");
        checkOutput("t5_write_count", 32'(log_b_n), 32'd4);
        checkOutput("t5_word_count", 32'(wc_b), 32'd4);
        checkOutput("t5_prog_addr_held", 32'(addr_b), 32'd3);
        checkOutput("t5_last_data", 32'(data_b), 32'h0404);
        checkOutput("t5_cpu_rst_n", 32'(crn_b), 32'd1);

        // Back-to-back frames, no idle gap
        applyStimulus(0, 8'hFF, 1);
        applyStimulus(0, 8'hFF, 1);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(0, 8'h00, 1);
        waitDone(0, "t6");
        checkOutput("t6_word0", 32'(log_a[0]), 32'hFFFF);
        checkOutput("t6_word1", 32'(log_a[1]), 32'h0000);
        checkOutput("t6_word_count", 32'(wc_a), 32'd2);

        step(4);
        checkOutput("queue_a_drained", 32'(exp_a.size()), 32'd0);
        checkOutput("queue_b_drained", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
